// File: rtl/svfloat.sv
// svfloat shared package: packed float types and a small helper class for
// per-format constants (exponent bias, infinity encoding).
//
// Contents:
//   float32 / float16 : packed {sign, exponent, mantissa} structs
//   ffunc#(float)     : static helpers bias() and inf(sign) for any such type
package svfloat;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;

  typedef struct packed {
    logic       sign;
    logic [4:0] exponent;
    logic [9:0] mantissa;
  } float16;

  virtual class ffunc #(parameter type float = float32);

    // Bias is half the all-ones exponent, i.e. 2^(E-1)-1, derived from the
    // type itself so every format gets the right value.
    static function int bias();
      float f;
      f = '0;
      f.exponent = '1;
      return int'(f.exponent) >> 1;
    endfunction

    // Infinity: all-ones exponent, zero mantissa, caller-chosen sign.
    static function float inf(input logic sign);
      float f;
      f = '0;
      f.sign = sign;
      f.exponent = '1;
      return f;
    endfunction

  endclass

endpackage

// File: rtl/svfloat_itof_round.sv
// svfloat_itof_round: combinational round-and-pack stage.
// Takes a normalized magnitude (hidden bit in the MSB) plus a biased exponent
// and produces the packed float, rounded to nearest-even, saturating to
// infinity when the exponent overflows. A zero magnitude packs as +0.
//
// Ports:
//   mag    : normalized magnitude, IWIDTH bits, MSB is the hidden bit
//   exp_in : biased exponent matching mag, EW bits
//   sign   : sign of the result
//   res    : packed float result
module svfloat_itof_round #(
  parameter type float  = svfloat::float32,
  parameter int  IWIDTH = 32,
  parameter int  EW     = 9
) (
  input  logic [IWIDTH-1:0] mag,
  input  logic [EW-1:0]     exp_in,
  input  logic              sign,
  output float              res
);

  localparam int E  = $bits(res.exponent);
  localparam int M  = $bits(res.mantissa);
  localparam int FW = IWIDTH - 1;

  logic [FW-1:0] frac;
  logic [M-1:0]  mant_trunc;
  logic          guard;
  logic          sticky;
  logic          round_up;
  logic [M:0]    mant_sum;
  logic [EW-1:0] exp_fin;

  assign frac = mag[FW-1:0];

  // Split the bits below the hidden bit into mantissa / guard / sticky.
  // Narrow integers fit entirely in the mantissa and are zero-padded, so
  // they never round.
  generate
    if (FW <= M) begin : g_exact
      assign mant_trunc = M'(frac) << (M - FW);
      assign guard      = 1'b0;
      assign sticky     = 1'b0;
    end else if (FW == M + 1) begin : g_guard_only
      assign mant_trunc = frac[FW-1:1];
      assign guard      = frac[0];
      assign sticky     = 1'b0;
    end else begin : g_round
      assign mant_trunc = frac[FW-1 -: M];
      assign guard      = frac[FW-1-M];
      assign sticky     = |frac[FW-2-M:0];
    end
  endgenerate

  // Round to nearest-even; a carry out of the mantissa leaves it all zero
  // and bumps the exponent by one.
  assign round_up = guard & (sticky | mant_trunc[0]);
  assign mant_sum = {1'b0, mant_trunc} + {{M{1'b0}}, round_up};
  assign exp_fin  = exp_in + {{(EW-1){1'b0}}, mant_sum[M]};

  // Pack, saturating to infinity once the exponent reaches the all-ones code.
  always_comb begin
    res = '0;
    if (mag[IWIDTH-1]) begin
      if (exp_fin >= EW'((2 ** E) - 1)) begin
        res = svfloat::ffunc#(float)::inf(sign);
      end else begin
        res.sign     = sign;
        res.exponent = exp_fin[E-1:0];
        res.mantissa = mant_sum[M-1:0];
      end
    end
  end

endmodule

// File: rtl/svfloat_itof.sv
// svfloat_itof: sequential integer-to-float converter.
// Accepts a signed or unsigned integer over a valid/ready handshake,
// normalizes it one bit per cycle, rounds to nearest-even and presents the
// packed float over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : input handshake (in_ready only in IDLE)
//   in_data, in_signed   : integer and its interpretation, sampled on accept
//   out_valid / out_ready: output handshake (out_valid only in DONE)
//   res                  : converted float, held stable while out_valid
module svfloat_itof #(
  parameter type float  = svfloat::float32,
  parameter int  IWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_data,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output float              res
);

  localparam int E = $bits(res.exponent);
  // Exponent counter holds bias+IWIDTH-1 plus a possible rounding carry,
  // with a spare bit so overflow compares never wrap.
  localparam int EW = $clog2((2 ** (E - 1)) + IWIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IWIDTH-1:0] mag;
  logic [EW-1:0]     exp_cnt;
  logic              sign_q;
  logic              in_neg;
  logic [IWIDTH-1:0] in_mag;
  float              rounded;

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Two's complement negation also maps the most negative value onto
  // 2^(IWIDTH-1), which is exactly its magnitude.
  assign in_neg = in_signed & in_data[IWIDTH-1];
  assign in_mag = in_neg ? ((~in_data) + IWIDTH'(1)) : in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: zero skips straight to DONE, otherwise shift until the
  // hidden bit reaches the MSB, round for one cycle, then wait for retirement.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (in_mag == '0) ? DONE : NORM;
      NORM:    if (mag[IWIDTH-1]) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift during NORM, latch the rounded result
  // at the end of ROUND. res is otherwise left alone so it stays stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag     <= '0;
      exp_cnt <= '0;
      sign_q  <= 1'b0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_neg;
            mag     <= in_mag;
            exp_cnt <= EW'(svfloat::ffunc#(float)::bias() + IWIDTH - 1);
            if (in_mag == '0) res <= '0;
          end
        end
        NORM: begin
          if (!mag[IWIDTH-1]) begin
            mag     <= mag << 1;
            exp_cnt <= exp_cnt - EW'(1);
          end
        end
        ROUND:   res <= rounded;
        default: ;
      endcase
    end
  end

  svfloat_itof_round #(
    .float (float),
    .IWIDTH(IWIDTH),
    .EW    (EW)
  ) u_round (
    .mag   (mag),
    .exp_in(exp_cnt),
    .sign  (sign_q),
    .res   (rounded)
  );

endmodule

// File: tb/tb_svfloat_itof.sv
// tb_svfloat_itof: scoreboard bench for svfloat_itof.
// Two instances (float32 and float16, both with 32-bit integer inputs) share
// clock and reset. The stimulus side pushes expected results and latencies
// into per-instance queues; a monitor pops and compares as results retire.
module tb_svfloat_itof;

  logic clk;
  logic rst_n;

  logic              in_valid32, in_ready32, in_signed32, out_valid32, out_ready32;
  logic [31:0]       in_data32;
  svfloat::float32   res32;
  logic              in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
  logic [31:0]       in_data16;
  svfloat::float16   res16;

  typedef struct {
    logic [31:0] expv;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    int          u;
    logic [31:0] d;
    bit          sg;
    logic [31:0] expv;
  } vec_t;

  exp_t        q32[$];
  exp_t        q16[$];
  vec_t        vecs[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          hold[2];
  bit          seen[2];
  logic [31:0] held[2];

  svfloat_itof #(.float(svfloat::float32), .IWIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_signed(in_signed32),
    .out_valid(out_valid32), .out_ready(out_ready32), .res(res32)
  );

  svfloat_itof #(.float(svfloat::float16), .IWIDTH(32)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_signed(in_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .res(res16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference: find the leading one, scale to M fraction bits, round
  // half-to-even on the discarded remainder, renormalize on carry, and
  // saturate to infinity once the biased exponent reaches all ones.
  function automatic void model(input logic [31:0] d, input bit sg, input int ew, input int mw,
                                output logic [31:0] bits, output int lat);
    logic [63:0] mag, q, rem, half, r;
    int p, sh, biased;
    bit s;
    s = sg && d[31];
    mag = {32'd0, d};
    if (s) mag = 64'h1_0000_0000 - mag;
    bits = '0;
    lat = 1;
    if (mag == 64'd0) return;
    p = 63;
    while (!mag[p]) p--;
    lat = (31 - p) + 3;
    if (p <= mw) begin
      q = mag << (mw - p);
    end else begin
      sh = p - mw;
      q = mag >> sh;
      rem = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    biased = p + (1 << (ew - 1)) - 1;
    r = 64'(s) << (ew + mw);
    if (biased >= (1 << ew) - 1) r = r | (((64'd1 << ew) - 64'd1) << mw);
    else r = r | (64'(biased) << mw) | (q & ((64'd1 << mw) - 64'd1));
    bits = r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Wait for in_ready, present one integer, and record the expectation at the
  // acceptance edge. A constant expectation overrides the model when given.
  task automatic applyStimulus(input int u, input logic [31:0] d, input bit sg,
                               input bit use_const, input logic [31:0] const_exp);
    int guard_cnt;
    exp_t e;
    logic [31:0] mv;
    int lat;
    guard_cnt = 0;
    @(negedge clk);
    while (!((u == 0) ? in_ready32 : in_ready16)) begin
      @(negedge clk);
      guard_cnt++;
      if (guard_cnt > 500) begin
        checkOutput($sformatf("u%0d_accept_timeout", u), 32'd0, 32'd1);
        return;
      end
    end
    if (u == 0) begin
      in_valid32 = 1'b1; in_data32 = d; in_signed32 = sg;
    end else begin
      in_valid16 = 1'b1; in_data16 = d; in_signed16 = sg;
    end
    model(d, sg, (u == 0) ? 8 : 5, (u == 0) ? 23 : 10, mv, lat);
    @(posedge clk);
    #1;
    e.expv = use_const ? const_exp : mv;
    e.lat  = lat;
    e.acc  = cyc;
    if (u == 0) begin
      q32.push_back(e);
      in_valid32 = 1'b0; in_data32 = $urandom; in_signed32 = 1'($urandom_range(0, 1));
    end else begin
      q16.push_back(e);
      in_valid16 = 1'b0; in_data16 = $urandom; in_signed16 = 1'($urandom_range(0, 1));
    end
  endtask

  // One monitor step per instance: check latency when out_valid first rises,
  // check res stability while held, compare and pop on retirement.
  task automatic monitorUnit(input int u);
    logic ov, ordy;
    logic [31:0] r;
    int qsz;
    exp_t head;
    if (!rst_n) begin
      seen[u] = 1'b0;
      if (u == 0) out_ready32 = 1'b0; else out_ready16 = 1'b0;
      return;
    end
    if (u == 0) begin
      ov = out_valid32; r = res32; qsz = q32.size();
      if (qsz > 0) head = q32[0];
    end else begin
      ov = out_valid16; r = {16'd0, res16}; qsz = q16.size();
      if (qsz > 0) head = q16[0];
    end
    ordy = hold[u] ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (ov) begin
      if (qsz == 0) begin
        checkOutput($sformatf("u%0d_spurious_valid", u), 32'd1, 32'd0);
        ordy = 1'b1;
      end else begin
        if (!seen[u]) begin
          checkOutput($sformatf("u%0d_latency", u), 32'(cyc - head.acc + 1), 32'(head.lat));
          seen[u] = 1'b1;
          held[u] = r;
        end else begin
          checkOutput($sformatf("u%0d_res_stable", u), r, held[u]);
        end
        if (ordy) begin
          checkOutput($sformatf("u%0d_result", u), r, head.expv);
          seen[u] = 1'b0;
          if (u == 0) void'(q32.pop_front()); else void'(q16.pop_front());
        end
      end
    end
    if (u == 0) out_ready32 = ordy; else out_ready16 = ordy;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitorUnit(0);
      monitorUnit(1);
    end
  end

  task automatic waitDrain();
    int n;
    n = 0;
    while (q32.size() != 0 || q16.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checkOutput("drain_timeout", 32'(q32.size() + q16.size()), 32'd0);
        q32.delete();
        q16.delete();
      end
    end
  endtask

  initial begin
    #5000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [31:0] d;
    bit sg;
    int u, n;
    rst_n = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; in_signed32 = 1'b0; out_ready32 = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; in_signed16 = 1'b0; out_ready16 = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready32", {31'd0, in_ready32}, 32'd1);
    checkOutput("reset_out_valid32", {31'd0, out_valid32}, 32'd0);
    checkOutput("reset_res32", res32, 32'd0);
    checkOutput("reset_in_ready16", {31'd0, in_ready16}, 32'd1);
    checkOutput("reset_out_valid16", {31'd0, out_valid16}, 32'd0);
    checkOutput("reset_res16", {16'd0, res16}, 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{0, 32'd1,          1'b0, 32'h3F800000});
    vecs.push_back('{0, 32'hFFFFFFFF,   1'b1, 32'hBF800000});
    vecs.push_back('{0, 32'h80000000,   1'b1, 32'hCF000000});
    vecs.push_back('{0, 32'h80000000,   1'b0, 32'h4F000000});
    vecs.push_back('{0, 32'hFFFFFFFF,   1'b0, 32'h4F800000});
    vecs.push_back('{0, 32'd16777217,   1'b0, 32'h4B800000});
    vecs.push_back('{0, 32'd16777219,   1'b0, 32'h4B800002});
    vecs.push_back('{0, 32'd0,          1'b0, 32'h00000000});
    vecs.push_back('{0, 32'd0,          1'b1, 32'h00000000});
    vecs.push_back('{1, 32'd65504,      1'b0, 32'h00007BFF});
    vecs.push_back('{1, 32'd65520,      1'b0, 32'h00007C00});
    vecs.push_back('{1, 32'd65536,      1'b0, 32'h00007C00});
    vecs.push_back('{1, 32'hFFFF0000,   1'b1, 32'h0000FC00});
    vecs.push_back('{1, 32'd1,          1'b0, 32'h00003C00});
    foreach (vecs[i]) applyStimulus(vecs[i].u, vecs[i].d, vecs[i].sg, 1'b1, vecs[i].expv);

    for (int i = 0; i < 100; i++) begin
      u  = $urandom_range(0, 1);
      sg = 1'($urandom_range(0, 1));
      d  = $urandom >> ((u == 0) ? $urandom_range(0, 31) : $urandom_range(8, 31));
      if (sg && $urandom_range(0, 1) == 1) d = -d;
      applyStimulus(u, d, sg, 1'b0, 32'd0);
    end
    waitDrain();

    // Back-pressure: result held in DONE, new input ignored meanwhile.
    hold[0] = 1'b1;
    applyStimulus(0, 32'd5, 1'b0, 1'b1, 32'h40A00000);
    n = 0;
    while (!out_valid32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_reached_done", {31'd0, out_valid32}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      in_valid32 = 1'b1; in_data32 = $urandom; in_signed32 = 1'($urandom_range(0, 1));
      checkOutput("hold_in_ready", {31'd0, in_ready32}, 32'd0);
      checkOutput("hold_out_valid", {31'd0, out_valid32}, 32'd1);
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    hold[0] = 1'b0;
    waitDrain();

    // Asynchronous reset in the middle of normalization.
    applyStimulus(0, 32'd1, 1'b0, 1'b1, 32'h3F800000);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", {31'd0, in_ready32}, 32'd1);
    checkOutput("midreset_out_valid", {31'd0, out_valid32}, 32'd0);
    checkOutput("midreset_res", res32, 32'd0);
    q32.delete();
    q16.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 32'd3, 1'b0, 1'b1, 32'h40400000);
    applyStimulus(0, 32'hFFFFFFFD, 1'b1, 1'b1, 32'hC0400000);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svfloat_itof.md
# svfloat_itof

Sequential integer-to-floating-point converter for the svfloat library. It accepts a signed or unsigned integer over a valid/ready handshake and normalizes it with a one-bit-per-cycle shifter. It rounds to nearest-even and presents the packed float result over a second valid/ready handshake. It is the producing-side counterpart to the float sign/format utilities: where those take a float apart and reassemble it, this block builds a float from raw integer data for the arithmetic pipeline.

## Interface
- `float`, default `svfloat::float32`: floating-point type with `sign`, `exponent`, `mantissa` fields; exponent width E, mantissa width M.
- `IWIDTH`, default 32: integer input width, ≥ 2.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset. Asynchronous and active-low.
- `in_valid` input 1: input integer present.
- `in_ready` output 1: block can accept input.
- `in_data` input IWIDTH: integer to convert.
- `in_signed` input 1: treat `in_data` as two's complement.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `res` output float: converted value.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - NORM: shift.
  - ROUND: round and pack.
  - DONE: `out_valid`=1.
- IDLE, on `in_valid`&&`in_ready`:
  - Capture sign s = `in_signed` & `in_data[IWIDTH-1]`.
  - Capture magnitude mag = s ? -`in_data` : `in_data`, as IWIDTH-bit unsigned. The most negative integer yields 2^(IWIDTH-1) exactly.
  - Set exponent counter to bias+IWIDTH-1, with bias = 2^(E-1)-1. The counter is wide enough to hold it.
  - If mag==0, go to DONE with `res`=+0 (sign 0). Otherwise go to NORM.
- NORM, each cycle:
  - If mag[IWIDTH-1]=1, go to ROUND.
  - Else mag <<= 1 and exponent counter -= 1.
- ROUND:
  - mag[IWIDTH-1] is the hidden bit.
  - Mantissa is the next M bits, zero-padded on the right if IWIDTH-1 < M (exact, no rounding).
  - Guard is the bit below the mantissa; sticky is the OR of all remaining bits.
  - Increment the mantissa when guard && (sticky || mantissa LSB).
  - Mantissa carry-out clears the mantissa and increments the exponent.
  - If the final exponent is ≥ 2^E-1, `res` = infinity with sign s.
  - Register `res` and go to DONE.
- DONE: hold `res` and `out_valid` stable until `out_ready`=1, then go to IDLE.
- `in_ready` is asserted only in IDLE. There is no acceptance in the same cycle as result retirement.
- NaN and subnormal results cannot occur.
- Reset (any state, including mid-NORM or DONE):
  - Go to IDLE.
  - `in_ready`=1, `out_valid`=0, `res`=0.
  - Internal registers cleared; any in-flight conversion is discarded.

## Timing
- Acceptance edge is cycle 0. k = leading-zero count of mag (0..IWIDTH-1).
- Nonzero input: NORM occupies cycles 1..k+1, ROUND is cycle k+2, `out_valid` rises at cycle k+3.
- Zero input: `out_valid` rises at cycle 1.
- Retirement edge: `out_valid` falls and `in_ready` rises in the following cycle. Next acceptance is possible one cycle after retirement.
- Throughput is one conversion per k+4 cycles with `out_ready` held at 1.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.
- `in_data` and `in_signed` are sampled only on the acceptance edge.

## Structure
- Use the existing `svfloat` package and `svfloat::ffunc#(float)` for field widths, bias and infinity construction.
- Add package helpers `svfloat::ffunc#(float)::bias()` and `::inf(sign)` if absent.
- Put the state enum (IDLE/NORM/ROUND/DONE) local to the module.
- Use one combinational sub-module, `svfloat_itof_round`:
  - Inputs: normalized magnitude and exponent.
  - Outputs: packed float or infinity.
  - Reusable by later float-from-fixed converters.

## Test plan
- float32, `in_signed`=0, `in_data`=1:
  - `res`=0x3F800000.
  - `out_valid` at cycle 34 (k=31).
- float32, signed inputs:
  - 0xFFFFFFFF → 0xBF800000.
  - 0x80000000 → 0xCF000000, `out_valid` at cycle 3.
- float32, unsigned inputs:
  - 0x80000000 → 0x4F000000.
  - 0xFFFFFFFF → 0x4F800000 (rounding carry into exponent).
- float32, rounding:
  - 16777217 → 0x4B800000 (tie to even, down).
  - 16777219 → 0x4B800002 (tie to even, up).
  - 0 → 0x00000000 with `out_valid` at cycle 1.
- float16, unsigned inputs:
  - 65504 → 0x7BFF.
  - 65520 → 0x7C00 (rounds to infinity).
  - 65536 → 0x7C00.
  - signed −65536 → 0xFC00.
- Handshake and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE: `res` stable, `in_ready`=0, a new `in_valid` is ignored.
  - Assert `rst_n`=0 mid-NORM: outputs reset immediately (asynchronously), the next conversion after release is correct.
